// File: rtl/instruction_loader.sv
// Byte-stream instruction loader: assembles 9-bit words and writes them to
// instruction memory, holding the CPU in reset until the program is loaded.
module instruction_loader #(
    parameter int INSTR_WIDTH = 9,
    parameter int ADDR_WIDTH  = 12,
    parameter int MAX_WORDS   = 4096,
    parameter int BASE_ADDR   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_waddr,
    output logic [INSTR_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH:0]    words_written,
    output logic                   done,
    output logic                   error,
    output logic                   cpu_hold
);

    localparam int WW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
        DONE,
        ERROR
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [7:0]            len_lo_q;
    logic [15:0]           len_q;
    logic [7:0]            lo_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic [15:0] len_in;
    logic        len_bad;
    logic        len_zero;
    logic        hi_bad;
    logic        last_word;
    logic        start_ok;
    logic        accept;
    logic        wr_fire;

    assign len_in    = {in_data, len_lo_q};
    assign len_bad   = {1'b0, len_in} > MAX_N;
    assign len_zero  = len_in == 16'd0;
    assign hi_bad    = in_data[7:1] != 7'd0;
    assign last_word = (17'(words_written) + 17'd1) == {1'b0, len_q};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) state_d = LEN_LO;
            end
            LEN_LO: begin
                if (accept) state_d = LEN_HI;
            end
            LEN_HI: begin
                if (accept) begin
                    if (len_bad)       state_d = ERROR;
                    else if (len_zero) state_d = DONE;
                    else               state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (accept) state_d = DATA_HI;
            end
            DATA_HI: begin
                if (accept) begin
                    if (hi_bad)         state_d = ERROR;
                    else if (last_word) state_d = DONE;
                    else                state_d = DATA_LO;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        start_ok = 1'b0;
        unique case (state_q)
            LEN_LO, LEN_HI, DATA_LO, DATA_HI: in_ready = 1'b1;
            default:                          start_ok = start;
        endcase
        accept  = in_ready && in_valid;
        wr_fire = accept && (state_q == DATA_HI) && !hi_bad;
    end

    // Write port is registered: the strobe lands one cycle after the
    // accepting high-byte edge, together with the counter and done.
    always_ff @(posedge clk) begin
        if (!reset) begin
            len_lo_q      <= '0;
            len_q         <= '0;
            lo_q          <= '0;
            addr_q        <= BASE;
            mem_we        <= 1'b0;
            mem_waddr     <= '0;
            mem_wdata     <= '0;
            words_written <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            cpu_hold      <= 1'b1;
        end else begin
            mem_we <= wr_fire;
            if (start_ok) begin
                addr_q        <= BASE;
                words_written <= '0;
                done          <= 1'b0;
                error         <= 1'b0;
                cpu_hold      <= 1'b1;
            end else begin
                if (done) cpu_hold <= 1'b0;
                if (accept) begin
                    unique case (state_q)
                        LEN_LO: len_lo_q <= in_data;
                        LEN_HI: begin
                            len_q <= len_in;
                            if (len_bad)       error <= 1'b1;
                            else if (len_zero) done  <= 1'b1;
                        end
                        DATA_LO: lo_q <= in_data;
                        DATA_HI: begin
                            if (hi_bad) begin
                                error <= 1'b1;
                            end else begin
                                mem_waddr     <= addr_q;
                                mem_wdata     <= INSTR_WIDTH'({in_data[0], lo_q});
                                addr_q        <= addr_q + ADDR_WIDTH'(1);
                                words_written <= words_written + WW'(1);
                                if (last_word) done <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized self-checking bench for instruction_loader; two instances
// (base 0 and base 4094) see the same stream.
module tb_instruction_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    wire [1:0]  ready_v, we_v, done_v, error_v, hold_v;
    wire [11:0] waddr_v [2];
    wire [8:0]  wdata_v [2];
    wire [12:0] ww_v [2];

    always #5 clk = ~clk;

    instruction_loader #(.BASE_ADDR(0)) u_base0 (
        .clk(clk), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(ready_v[0]),
        .mem_we(we_v[0]), .mem_waddr(waddr_v[0]), .mem_wdata(wdata_v[0]),
        .words_written(ww_v[0]), .done(done_v[0]), .error(error_v[0]),
        .cpu_hold(hold_v[0])
    );

    instruction_loader #(.BASE_ADDR(4094)) u_wrap (
        .clk(clk), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(ready_v[1]),
        .mem_we(we_v[1]), .mem_waddr(waddr_v[1]), .mem_wdata(wdata_v[1]),
        .words_written(ww_v[1]), .done(done_v[1]), .error(error_v[1]),
        .cpu_hold(hold_v[1])
    );

    typedef struct packed {
        logic [11:0] a;
        logic [8:0]  d;
        logic        dn;
        logic        h;
    } wr_t;

    int   bases [2] = '{0, 4094};
    wr_t  wq [2][$];
    logic [1:0] prev_we = 2'b00;
    logic [1:0] wide = 2'b00;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] stream [$];
    logic [8:0] exp_words [$];
    bit exp_done;
    bit exp_err;

    // Capture every write strobe, plus done/hold as seen alongside it
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (we_v[k] === 1'b1) begin
                wq[k].push_back('{a: waddr_v[k], d: wdata_v[k],
                                  dn: done_v[k], h: hold_v[k]});
                if (prev_we[k]) wide[k] = 1'b1;
            end
            prev_we[k] = we_v[k];
        end
    end

    // Reference: parse the byte stream directly into the expected program
    task automatic model();
        int n;
        logic [7:0] hi;
        exp_words.delete();
        exp_done = 0;
        exp_err = 0;
        if (stream.size() < 2) return;
        n = {stream[1], stream[0]};
        if (n > 4096) begin
            exp_err = 1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (3 + 2 * i >= stream.size()) return;
            hi = stream[3 + 2 * i];
            if (hi[7:1] != 7'd0) begin
                exp_err = 1;
                return;
            end
            exp_words.push_back({hi[0], stream[2 + 2 * i]});
        end
        exp_done = 1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int g;
        g = stall ? int'($urandom_range(0, 3)) : 0;
        repeat (g) begin
            in_valid = 1'b0;
            in_data = 8'($urandom);
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
        in_valid = 1'b1;
        in_data = b;
        for (int t = 0; t < 20; t++) begin
            if (ready_v[0] === 1'b1) begin
                @(negedge clk);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        n_fail++;
        $display("FAIL send_byte_timeout: in_ready=%b required 1 (byte %02h)",
                 ready_v[0], b);
    endtask

    task automatic run_load(input bit stall);
        int ne;
        model();
        wq[0].delete();
        wq[1].delete();
        wide = 2'b00;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({done_v[k], error_v[k], ww_v[k], hold_v[k], ready_v[k]}
                !== {1'b0, 1'b0, 13'd0, 1'b1, 1'b1}) begin
                n_fail++;
                $display("FAIL start_clear[%0d]: done=%b err=%b ww=%0d hold=%b rdy=%b required 0 0 0 1 1",
                         k, done_v[k], error_v[k], ww_v[k], hold_v[k], ready_v[k]);
            end
        end
        foreach (stream[i]) send_byte(stream[i], stall);
        repeat (3) @(negedge clk);
        #1;
        ne = exp_words.size();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (wq[k].size() !== ne) begin
                n_fail++;
                $display("FAIL write_count[%0d]: got %0d required %0d",
                         k, wq[k].size(), ne);
            end
            for (int i = 0; i < ne && i < wq[k].size(); i++) begin
                n_checks++;
                if (wq[k][i].a !== 12'((bases[k] + i) % 4096) ||
                    wq[k][i].d !== exp_words[i] ||
                    wq[k][i].dn !== (exp_done && i == ne - 1) ||
                    wq[k][i].h !== 1'b1) begin
                    n_fail++;
                    $display("FAIL write[%0d][%0d]: %03h@%0d dn=%b h=%b required %03h@%0d dn=%b h=1",
                             k, i, wq[k][i].d, wq[k][i].a, wq[k][i].dn, wq[k][i].h,
                             exp_words[i], (bases[k] + i) % 4096,
                             exp_done && i == ne - 1);
                end
            end
            n_checks++;
            if ({done_v[k], error_v[k], ww_v[k], hold_v[k], ready_v[k], wide[k]}
                !== {exp_done, exp_err, 13'(ne), !exp_done, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL final[%0d]: done=%b err=%b ww=%0d hold=%b rdy=%b wide=%b required %b %b %0d %b 0 0",
                         k, done_v[k], error_v[k], ww_v[k], hold_v[k], ready_v[k],
                         wide[k], exp_done, exp_err, ne, !exp_done);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({ready_v[k], we_v[k], waddr_v[k], wdata_v[k], ww_v[k],
                 done_v[k], error_v[k], hold_v[k]}
                !== {1'b0, 1'b0, 12'd0, 9'd0, 13'd0, 1'b0, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL %s[%0d]: rdy=%b we=%b a=%0d d=%03h ww=%0d done=%b err=%b hold=%b required reset values",
                         tag, k, ready_v[k], we_v[k], waddr_v[k], wdata_v[k],
                         ww_v[k], done_v[k], error_v[k], hold_v[k]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("reset_state");
        start = 1'b0;
        reset = 1'b1;
        wq[0].delete();
        wq[1].delete();
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (ready_v !== 2'b00 || wq[0].size() != 0 || hold_v !== 2'b11) begin
            n_fail++;
            $display("FAIL idle_no_accept: rdy=%b writes=%0d hold=%b required 00 0 11",
                     ready_v, wq[0].size(), hold_v);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        stream = '{8'h03, 8'h00, 8'hFF, 8'h01, 8'h12, 8'h00, 8'h34, 8'h01};
        run_load(0);
        n_checks++;
        if (wq[0].size() != 3 || wq[0][0].d !== 9'h1FF || wq[0][1].d !== 9'h012 ||
            wq[0][2].d !== 9'h134 || wq[0][2].a !== 12'd2) begin
            n_fail++;
            $display("FAIL basic_literal: got %0d writes, required 1FF@0 012@1 134@2",
                     wq[0].size());
        end
    endtask

    task automatic test_stalls();
        stream = '{8'h03, 8'h00, 8'hFF, 8'h01, 8'h12, 8'h00, 8'h34, 8'h01};
        run_load(1);
        for (int r = 0; r < 2; r++) begin
            int n;
            n = $urandom_range(1, 12);
            stream = '{8'(n), 8'h00};
            for (int i = 0; i < n; i++) begin
                stream.push_back(8'($urandom));
                stream.push_back(8'($urandom_range(0, 1)));
            end
            run_load(1);
        end
    endtask

    task automatic test_errors();
        stream = '{8'h01, 8'h10};
        run_load(0);
        stream = '{8'h02, 8'h00, 8'($urandom), 8'($urandom_range(0, 1)),
                   8'($urandom), 8'h02};
        run_load(1);
        n_checks++;
        if (ww_v[0] !== 13'd1 || error_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_hi: ww=%0d err=%b required 1 1", ww_v[0], error_v[0]);
        end
    endtask

    task automatic test_empty_restart();
        stream = '{8'h00, 8'h00};
        run_load(0);
        stream = '{8'h01, 8'h00, 8'hAA, 8'h00};
        run_load(0);
    endtask

    task automatic test_wrap();
        stream = '{8'h03, 8'h00};
        for (int i = 0; i < 3; i++) begin
            stream.push_back(8'($urandom));
            stream.push_back(8'($urandom_range(0, 1)));
        end
        run_load(1);
        n_checks++;
        if (wq[1].size() != 3 || wq[1][0].a !== 12'd4094 ||
            wq[1][1].a !== 12'd4095 || wq[1][2].a !== 12'd0 ||
            done_v[1] !== 1'b1 || error_v[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_addr: writes=%0d done=%b err=%b required 4094 4095 0 done=1 err=0",
                     wq[1].size(), done_v[1], error_v[1]);
        end
    endtask

    task automatic test_reset_mid();
        wq[0].delete();
        wq[1].delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        send_byte(8'h5A, 0);
        send_byte(8'h01, 0);
        send_byte(8'h77, 0);
        in_valid = 1'b1;
        in_data = 8'h01;
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        #1;
        check_reset_values("reset_mid");
        n_checks++;
        if (wq[0].size() != 1) begin
            n_fail++;
            $display("FAIL reset_mid_writes: got %0d required 1", wq[0].size());
        end
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (ready_v !== 2'b00 || hold_v !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_start_ignored: rdy=%b hold=%b required 00 11",
                     ready_v, hold_v);
        end
        stream = '{8'h04, 8'h00};
        for (int i = 0; i < 4; i++) begin
            stream.push_back(8'($urandom));
            stream.push_back(8'($urandom_range(0, 1)));
        end
        run_load(1);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(0, 10);
            stream = '{8'(n), 8'h00};
            for (int i = 0; i < n; i++) begin
                stream.push_back(8'($urandom));
                if ($urandom_range(0, 15) == 0) begin
                    stream.push_back(8'($urandom_range(2, 255)));
                    break;
                end
                stream.push_back(8'($urandom_range(0, 1)));
            end
            run_load(r[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_errors();
        test_empty_restart();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
